// File: rtl/dragon_mover.sv
// Dragon motion unit: walks the dragon one grid cell per MOVE_DIV frame
// ticks toward the selected target, with a hit-freeze and reached pulses.
module dragon_mover #(
  parameter int unsigned MOVE_DIV    = 4,
  parameter int unsigned HURT_FRAMES = 16,
  parameter logic [7:0]  START_POS   = 8'hB5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] target_pos,
  input  logic [7:0] player_pos,
  input  logic [7:0] sheep_pos,
  input  logic       dragon_hurt,
  output logic [7:0] dragon_pos,
  output logic [1:0] dragon_direction,
  output logic [6:0] dragon_state,
  output logic       target_reached_player,
  output logic       target_reached_sheep
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_HURT
  } state_t;

  localparam logic [3:0] PRE_LAST = 4'(MOVE_DIV - 1);
  localparam logic [7:0] HURT_LD  = 8'(HURT_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] pre_q, pre_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] pos_q, pos_d;
  logic [1:0] dir_q, dir_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rp_q, rp_d;
  logic       rs_q, rs_d;

  logic [3:0] tx, ty, x, y;
  logic [3:0] adx, ady;
  logic       step_x;
  logic [7:0] tgt;
  logic [7:0] nxt_pos;
  logic [1:0] nxt_dir;

  // Rows beyond the playfield collapse onto the bottom row.
  always_comb begin
    tx  = target_pos[7:4];
    ty  = (target_pos[3:0] > 4'd11) ? 4'd11 : target_pos[3:0];
    tgt = {tx, ty};
    x   = pos_q[7:4];
    y   = pos_q[3:0];
    adx = (tx >= x) ? tx - x : x - tx;
    ady = (ty >= y) ? ty - y : y - ty;
    step_x = (adx >= ady);
  end

  always_comb begin
    nxt_pos = pos_q;
    nxt_dir = dir_q;
    unique case (1'b1)
      step_x && (tx > x): begin
        nxt_pos = {x + 4'd1, y};
        nxt_dir = 2'd1;
      end
      step_x && (tx <= x): begin
        nxt_pos = {x - 4'd1, y};
        nxt_dir = 2'd3;
      end
      !step_x && (ty > y): begin
        nxt_pos = {x, y + 4'd1};
        nxt_dir = 2'd2;
      end
      !step_x && (ty <= y): begin
        nxt_pos = {x, y - 4'd1};
        nxt_dir = 2'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    hcnt_d  = hcnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    rp_d    = 1'b0;
    rs_d    = 1'b0;
    if (dragon_hurt) begin
      state_d = S_HURT;
      hcnt_d  = HURT_LD;
      cnt_d   = 3'd0;
    end else if (state_q == S_HURT) begin
      if (trigger) begin
        hcnt_d = hcnt_q - 8'd1;
        if (hcnt_q == 8'd1) begin
          state_d = S_IDLE;
          pre_d   = 4'd0;
        end
      end
    end else if (trigger) begin
      if (pos_q != tgt) begin
        if (pre_q == PRE_LAST) begin
          pre_d = 4'd0;
          pos_d = nxt_pos;
          dir_d = nxt_dir;
          if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
        end else begin
          pre_d = pre_q + 4'd1;
        end
      end
      if (pos_d == tgt) begin
        state_d = S_IDLE;
        rp_d    = (tgt == player_pos);
        rs_d    = (tgt == sheep_pos);
      end else begin
        state_d = S_MOVE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pre_q   <= 4'd0;
      hcnt_q  <= 8'd0;
      pos_q   <= START_POS;
      dir_q   <= 2'd0;
      cnt_q   <= 3'd0;
      rp_q    <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      hcnt_q  <= hcnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      rp_q    <= rp_d;
      rs_q    <= rs_d;
    end
  end

  assign dragon_pos            = pos_q;
  assign dragon_direction      = dir_q;
  assign dragon_state          = {state_q == S_HURT, state_q == S_MOVE,
                                  dir_q, cnt_q};
  assign target_reached_player = rp_q;
  assign target_reached_sheep  = rs_q;

endmodule
